// File: rtl/ins_mem_arbiter.sv
// rtl/ins_mem_arbiter.sv - round-robin sharing of one instruction memory among cores
// Program-load writes take priority; a tag pipeline routes each read response to its core.
module ins_mem_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int CORE_ID_W  = $clog2(NUM_CORES)
) (
   input  logic                            clock,
   input  logic                            resetN,
   input  logic [NUM_CORES-1:0]            coreReq,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] coreAddr,
   output logic [NUM_CORES-1:0]            coreGnt,
   output logic [NUM_CORES-1:0]            coreRvalid,
   output logic [WIDTH-1:0]                coreRdata,
   input  logic                            loadEn,
   input  logic [ADDR_WIDTH-1:0]           loadAddr,
   input  logic [WIDTH-1:0]                loadData,
   output logic                            memWriteEn,
   output logic [ADDR_WIDTH-1:0]           memAddress,
   output logic [WIDTH-1:0]                memDataIn,
   input  logic [WIDTH-1:0]                memDataOut
);

   logic [CORE_ID_W-1:0]  rr_ptr;
   logic [CORE_ID_W-1:0]  rr_next;
   logic [CORE_ID_W-1:0]  gnt_idx;
   logic                  found;
   int                    cand;
   logic [NUM_CORES-1:0]  s1;
   logic [NUM_CORES-1:0]  s2;
   logic [ADDR_WIDTH-1:0] core_addr [NUM_CORES];

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_addr
      assign core_addr[g] = coreAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // First requester at or after rr_ptr, wrapping around the core index space.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         cand = (int'(rr_ptr) + i) % NUM_CORES;
         if (!found && coreReq[CORE_ID_W'(cand)]) begin
            found   = 1'b1;
            gnt_idx = CORE_ID_W'(cand);
         end
      end
   end

   assign rr_next = (gnt_idx == CORE_ID_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      coreGnt    = '0;
      memWriteEn = 1'b0;
      memAddress = '0;
      if (resetN) begin
         if (loadEn) begin
            memWriteEn = 1'b1;
            memAddress = loadAddr;
         end else if (found) begin
            coreGnt[gnt_idx] = 1'b1;
            memAddress       = core_addr[gnt_idx];
         end
      end
   end

   assign memDataIn  = loadData;
   assign coreRvalid = s2;

   // s1 tags the access presented this cycle; s2 marks the cycle its data is returned.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         rr_ptr    <= '0;
         s1        <= '0;
         s2        <= '0;
         coreRdata <= '0;
      end else begin
         if (|coreGnt)
            rr_ptr <= rr_next;
         s1 <= coreGnt;
         s2 <= s1;
         if (|s1)
            coreRdata <= memDataOut;
      end
   end

endmodule

// File: tb/tb_ins_mem_arbiter.sv
// tb/tb_ins_mem_arbiter.sv - directed vector bench for ins_mem_arbiter with a registered-address memory model
module tb_ins_mem_arbiter;

   logic        clock = 1'b0;
   logic        resetN;
   logic [3:0]  coreReq;
   logic [31:0] coreAddr;
   logic [3:0]  coreGnt;
   logic [3:0]  coreRvalid;
   logic [7:0]  coreRdata;
   logic        loadEn;
   logic [7:0]  loadAddr;
   logic [7:0]  loadData;
   logic        memWriteEn;
   logic [7:0]  memAddress;
   logic [7:0]  memDataIn;
   logic [7:0]  memDataOut;

   logic [7:0]  mem [256];
   logic        mem_ready;

   int n_cmp = 0;
   int n_bad = 0;
   int row   = -1;

   typedef struct {
      logic        le;
      logic [7:0]  la;
      logic [7:0]  ld;
      logic [3:0]  req;
      logic [31:0] addr;
      logic [3:0]  gnt;
      logic        we;
      logic [7:0]  maddr;
      logic [3:0]  rv;
      logic [7:0]  rd;
   } vec_t;

   localparam int NV = 36;
   vec_t tbl [NV];

   ins_mem_arbiter dut (
      .clock      (clock),
      .resetN     (resetN),
      .coreReq    (coreReq),
      .coreAddr   (coreAddr),
      .coreGnt    (coreGnt),
      .coreRvalid (coreRvalid),
      .coreRdata  (coreRdata),
      .loadEn     (loadEn),
      .loadAddr   (loadAddr),
      .loadData   (loadData),
      .memWriteEn (memWriteEn),
      .memAddress (memAddress),
      .memDataIn  (memDataIn),
      .memDataOut (memDataOut)
   );

   always #5 clock = ~clock;

   // Memory starts with mem[a] = ~a; reads return the pre-write value.
   always @(posedge clock) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
         memDataOut <= 8'h00;
      end else begin
         if (memWriteEn) mem[memAddress] <= memDataIn;
         memDataOut <= mem[memAddress];
      end
   end

   function automatic vec_t mk(logic le, logic [7:0] la, logic [7:0] ld, logic [3:0] req,
                               logic [31:0] addr, logic [3:0] gnt, logic we, logic [7:0] maddr,
                               logic [3:0] rv, logic [7:0] rd);
      vec_t v;
      v.le = le; v.la = la; v.ld = ld; v.req = req; v.addr = addr;
      v.gnt = gnt; v.we = we; v.maddr = maddr; v.rv = rv; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      tbl[0]  = mk(1, 8'h10, 8'hA5, 4'h0, 32'h0,        4'b0000, 1, 8'h10, 4'b0000, 8'h00);
      tbl[1]  = mk(1, 8'h11, 8'h3C, 4'h0, 32'h0,        4'b0000, 1, 8'h11, 4'b0000, 8'h00);
      tbl[2]  = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'h00);
      tbl[3]  = mk(0, 8'h00, 8'h00, 4'hF, 32'h33323130, 4'b0001, 0, 8'h30, 4'b0000, 8'h00);
      tbl[4]  = mk(0, 8'h00, 8'h00, 4'hF, 32'h33323130, 4'b0010, 0, 8'h31, 4'b0000, 8'h00);
      tbl[5]  = mk(0, 8'h00, 8'h00, 4'hF, 32'h33323130, 4'b0100, 0, 8'h32, 4'b0001, 8'hCF);
      tbl[6]  = mk(0, 8'h00, 8'h00, 4'hF, 32'h33323130, 4'b1000, 0, 8'h33, 4'b0010, 8'hCE);
      tbl[7]  = mk(0, 8'h00, 8'h00, 4'hF, 32'h33323130, 4'b0001, 0, 8'h30, 4'b0100, 8'hCD);
      tbl[8]  = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b1000, 8'hCC);
      tbl[9]  = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0001, 8'hCF);
      tbl[10] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'hCF);
      tbl[11] = mk(0, 8'h00, 8'h00, 4'b0100, 32'h00100000, 4'b0100, 0, 8'h10, 4'b0000, 8'hCF);
      tbl[12] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'hCF);
      tbl[13] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0100, 8'hA5);
      tbl[14] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'hA5);
      tbl[15] = mk(0, 8'h00, 8'h00, 4'b0001, 32'h00000012, 4'b0001, 0, 8'h12, 4'b0000, 8'hA5);
      tbl[16] = mk(1, 8'h40, 8'h77, 4'b1010, 32'h10001100, 4'b0000, 1, 8'h40, 4'b0000, 8'hA5);
      tbl[17] = mk(1, 8'h41, 8'h78, 4'b1010, 32'h10001100, 4'b0000, 1, 8'h41, 4'b0001, 8'hED);
      tbl[18] = mk(1, 8'h42, 8'h79, 4'b1010, 32'h10001100, 4'b0000, 1, 8'h42, 4'b0000, 8'hED);
      tbl[19] = mk(0, 8'h00, 8'h00, 4'b1010, 32'h10001100, 4'b0010, 0, 8'h11, 4'b0000, 8'hED);
      tbl[20] = mk(0, 8'h00, 8'h00, 4'b1000, 32'h10001100, 4'b1000, 0, 8'h10, 4'b0000, 8'hED);
      tbl[21] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0010, 8'h3C);
      tbl[22] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b1000, 8'hA5);
      tbl[23] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'hA5);
      tbl[24] = mk(0, 8'h00, 8'h00, 4'b0001, 32'h00000011, 4'b0001, 0, 8'h11, 4'b0000, 8'hA5);
      tbl[25] = mk(1, 8'h11, 8'hFF, 4'h0, 32'h0,        4'b0000, 1, 8'h11, 4'b0000, 8'hA5);
      tbl[26] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0001, 8'h3C);
      tbl[27] = mk(0, 8'h00, 8'h00, 4'b0010, 32'h00001100, 4'b0010, 0, 8'h11, 4'b0000, 8'h3C);
      tbl[28] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'h3C);
      tbl[29] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0010, 8'hFF);
      tbl[30] = mk(0, 8'h00, 8'h00, 4'b1000, 32'h40000000, 4'b1000, 0, 8'h40, 4'b0000, 8'hFF);
      tbl[31] = mk(0, 8'h00, 8'h00, 4'b1001, 32'h42000041, 4'b0001, 0, 8'h41, 4'b0000, 8'hFF);
      tbl[32] = mk(0, 8'h00, 8'h00, 4'b1000, 32'h42000041, 4'b1000, 0, 8'h42, 4'b1000, 8'h77);
      tbl[33] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0001, 8'h78);
      tbl[34] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b1000, 8'h79);
      tbl[35] = mk(0, 8'h00, 8'h00, 4'h0, 32'h0,        4'b0000, 0, 8'h00, 4'b0000, 8'h79);

      resetN    = 1'b0;
      mem_ready = 1'b0;
      coreReq   = '0;
      coreAddr  = '0;
      loadEn    = 1'b0;
      loadAddr  = '0;
      loadData  = '0;

      // While held in reset, requests and loads must not reach the outputs.
      @(posedge clock);
      #1 mem_ready = 1'b1;
      loadEn  = 1'b1;
      loadAddr = 8'h55;
      coreReq = 4'hF;
      @(negedge clock);
      chk("rst_gnt", 32'(coreGnt), 32'h0);
      chk("rst_we", 32'(memWriteEn), 32'h0);
      chk("rst_rv", 32'(coreRvalid), 32'h0);
      chk("rst_rd", 32'(coreRdata), 32'h0);

      // Leave reset, grant core 1 so the pointer moves to 2, then reset with that read in flight.
      @(posedge clock);
      #1 resetN = 1'b1;
      loadEn   = 1'b0;
      loadAddr = '0;
      coreReq  = 4'b0010;
      coreAddr = 32'h00002000;
      @(negedge clock);
      chk("pre_gnt", 32'(coreGnt), 32'h2);
      @(posedge clock);
      #1 coreReq = '0;
      coreAddr = '0;
      #1 resetN = 1'b0;
      #1 chk("midrst_rv", 32'(coreRvalid), 32'h0);
      @(posedge clock);
      #1 resetN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("post_rst_rv", 32'(coreRvalid), 32'h0);
         @(posedge clock);
      end

      for (int r = 0; r < NV; r++) begin
         #1 row = r;
         loadEn   = tbl[r].le;
         loadAddr = tbl[r].la;
         loadData = tbl[r].ld;
         coreReq  = tbl[r].req;
         coreAddr = tbl[r].addr;
         @(negedge clock);
         chk("gnt", 32'(coreGnt), 32'(tbl[r].gnt));
         chk("we", 32'(memWriteEn), 32'(tbl[r].we));
         chk("maddr", 32'(memAddress), 32'(tbl[r].maddr));
         chk("mdin", 32'(memDataIn), 32'(tbl[r].ld));
         chk("rvalid", 32'(coreRvalid), 32'(tbl[r].rv));
         chk("rdata", 32'(coreRdata), 32'(tbl[r].rd));
         @(posedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
